// File: rtl/cpu_defs.sv
// cpu_defs: shared instruction-memory sizing, loader terminator and loader state encoding
package cpu_defs;
    localparam int INSTR_W = 32;
    localparam int IMEM_DEPTH = 32;
    localparam int IMEM_ADDR_W = 5;
    localparam logic [31:0] LOADER_TERM = 32'hFFFF_FFFF;
    typedef enum logic [1:0] {IDLE = 2'd0, RECV = 2'd1, DONE = 2'd2} state_t;
endpackage

// File: rtl/instruction_loader_byte_packer.sv
// byte_packer: packs an MSB-first byte stream into 32-bit words, flagging the 4th byte combinationally
module byte_packer (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_clr,
    input  logic        i_en,
    input  logic [7:0]  i_byte,
    output logic [31:0] o_word,
    output logic        o_word_valid
);
    logic [23:0] sr;
    logic [1:0]  idx;
    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr) begin
            sr  <= '0;
            idx <= '0;
        end else if (i_en) begin
            sr  <= {sr[15:0], i_byte};
            idx <= idx + 2'd1;
        end
    end
    assign o_word       = {sr, i_byte};
    assign o_word_valid = i_en && idx == 2'd3;
endmodule

// File: rtl/instruction_loader.sv
// instruction_loader: feeds UART bytes as 32-bit words into instruction memory, then releases the CPU
module instruction_loader
    import cpu_defs::*;
#(
    parameter int               DATA_W = INSTR_W,
    parameter int               DEPTH  = IMEM_DEPTH,
    parameter int               ADDR_W = IMEM_ADDR_W,
    parameter logic [DATA_W-1:0] TERM  = LOADER_TERM
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic [7:0]        i_rx_data,
    input  logic              i_rx_valid,
    output logic              o_Load_enable,
    output logic [31:0]       o_Write_reg,
    output logic [DATA_W-1:0] o_Write_data,
    output logic              o_busy,
    output logic              o_done,
    output logic [ADDR_W:0]   o_word_count,
    output logic              o_overflow
);
    state_t              state, next;
    logic                start_ok, accept, word_valid;
    logic [DATA_W-1:0]   word;
    logic [ADDR_W-1:0]   addr, wr_addr;
    assign start_ok = i_start && state != RECV;
    assign accept   = i_rx_valid && state == RECV;
    byte_packer u_packer (
        .i_clk(i_clk),
        .i_rst(i_rst),
        .i_clr(start_ok),
        .i_en(accept),
        .i_byte(i_rx_data),
        .o_word(word),
        .o_word_valid(word_valid)
    );
    // termination is judged on the word currently being strobed into memory
    always_comb begin
        next = start_ok ? RECV :
               (state == RECV && o_Load_enable &&
                (o_Write_data == TERM || o_word_count == (ADDR_W+1)'(DEPTH))) ? DONE : state;
    end
    always_ff @(posedge i_clk) begin
        if (i_rst) state <= IDLE;
        else state <= next;
    end
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_Load_enable <= 1'b0;
            o_Write_data  <= '0;
            wr_addr       <= '0;
            addr          <= '0;
            o_word_count  <= '0;
            o_overflow    <= 1'b0;
        end else begin
            o_Load_enable <= word_valid;
            if (word_valid) begin
                o_Write_data <= word;
                wr_addr      <= addr;
                addr         <= addr + 1'b1;
                o_word_count <= o_word_count + 1'b1;
            end
            if (start_ok) begin
                addr         <= '0;
                o_word_count <= '0;
                o_overflow   <= 1'b0;
            end else if (state == DONE && i_rx_valid) begin
                o_overflow <= 1'b1;
            end
        end
    end
    assign o_Write_reg = 32'(wr_addr);
    assign o_busy      = state == RECV;
    assign o_done      = state == DONE;
endmodule

// File: tb/tb_instruction_loader.sv
// tb_instruction_loader: directed self-checking bench for instruction_loader
module tb_instruction_loader;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  rx_data = '0;
    logic        rx_valid = 1'b0;
    logic        load_enable;
    logic [31:0] write_reg;
    logic [31:0] write_data;
    logic        busy;
    logic        done;
    logic [5:0]  word_count;
    logic        overflow;
    int          vectors = 0;
    int          miscompares = 0;
    int          strobes = 0;

    instruction_loader dut (
        .i_clk(clk),
        .i_rst(rst),
        .i_start(start),
        .i_rx_data(rx_data),
        .i_rx_valid(rx_valid),
        .o_Load_enable(load_enable),
        .o_Write_reg(write_reg),
        .o_Write_data(write_data),
        .o_busy(busy),
        .o_done(done),
        .o_word_count(word_count),
        .o_overflow(overflow)
    );

    always #5 clk = ~clk;
    always @(posedge clk) if (load_enable) strobes++;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 3; i >= 0; i--) send_byte(w[i*8 +: 8]);
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic begin_session();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic test_reset();
        reset_dut();
        vectors++;
        if ({load_enable, write_reg, write_data, busy, done, word_count, overflow} !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs: le=%b reg=%h data=%h busy=%b done=%b cnt=%0d ovf=%b, want all 0",
                     load_enable, write_reg, write_data, busy, done, word_count, overflow);
        end
    endtask

    task automatic test_single_word();
        begin_session();
        vectors++;
        if (busy !== 1'b1) begin
            miscompares++;
            $display("FAIL start_busy: got %b want 1", busy);
        end
        send_word(32'h2001_0005);
        vectors++;
        if ({load_enable, write_reg, write_data, word_count} !== {1'b1, 32'd0, 32'h2001_0005, 6'd1}) begin
            miscompares++;
            $display("FAIL single_write: le=%b reg=%0d data=%h cnt=%0d want le=1 reg=0 data=20010005 cnt=1",
                     load_enable, write_reg, write_data, word_count);
        end
        tick();
        vectors++;
        if (load_enable !== 1'b0) begin
            miscompares++;
            $display("FAIL single_strobe_width: le=%b want 0", load_enable);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_w [3] = '{32'h1011_1213, 32'h1415_1617, 32'h1819_1A1B};
        reset_dut();
        begin_session();
        for (int i = 0; i < 12; i++) begin
            send_byte(8'(8'h10 + i));
            vectors++;
            if (load_enable !== (i % 4 == 3)) begin
                miscompares++;
                $display("FAIL b2b_strobe[%0d]: le=%b want %b", i, load_enable, (i % 4 == 3));
            end
            if (i % 4 == 3) begin
                vectors++;
                if (write_reg !== 32'(i / 4) || write_data !== exp_w[i/4]) begin
                    miscompares++;
                    $display("FAIL b2b_word[%0d]: reg=%0d data=%h want reg=%0d data=%h",
                             i / 4, write_reg, write_data, i / 4, exp_w[i/4]);
                end
            end
        end
    endtask

    task automatic test_terminator();
        reset_dut();
        begin_session();
        send_word(32'hDEAD_BEEF);
        send_word(32'h0000_0013);
        send_word(32'hFFFF_FFFF);
        vectors++;
        if ({load_enable, write_reg, write_data, word_count, busy} !== {1'b1, 32'd2, 32'hFFFF_FFFF, 6'd3, 1'b1}) begin
            miscompares++;
            $display("FAIL term_write: le=%b reg=%0d data=%h cnt=%0d busy=%b want 1,2,ffffffff,3,1",
                     load_enable, write_reg, write_data, word_count, busy);
        end
        tick();
        vectors++;
        if ({done, busy, word_count, load_enable} !== {1'b1, 1'b0, 6'd3, 1'b0}) begin
            miscompares++;
            $display("FAIL term_done: done=%b busy=%b cnt=%0d le=%b want 1,0,3,0", done, busy, word_count, load_enable);
        end
    endtask

    task automatic test_full_memory();
        int s0;
        reset_dut();
        begin_session();
        s0 = strobes;
        for (int w = 0; w < 33; w++) begin
            send_word(32'hA500_0000 | 32'(w));
            vectors++;
            if (w < 32) begin
                if (load_enable !== 1'b1 || write_reg !== 32'(w) || write_data !== (32'hA500_0000 | 32'(w))
                    || word_count !== 6'(w + 1)) begin
                    miscompares++;
                    $display("FAIL full_write[%0d]: le=%b reg=%0d data=%h cnt=%0d", w, load_enable, write_reg,
                             write_data, word_count);
                end
            end else if (load_enable !== 1'b0) begin
                miscompares++;
                $display("FAIL full_extra_strobe: le=%b want 0", load_enable);
            end
        end
        tick();
        vectors++;
        if ({done, busy, overflow, word_count} !== {1'b1, 1'b0, 1'b1, 6'd32}) begin
            miscompares++;
            $display("FAIL full_done: done=%b busy=%b ovf=%b cnt=%0d want 1,0,1,32", done, busy, overflow, word_count);
        end
        vectors++;
        if (strobes - s0 !== 32) begin
            miscompares++;
            $display("FAIL full_strobe_count: got %0d want 32", strobes - s0);
        end
    endtask

    task automatic test_mid_reset();
        reset_dut();
        begin_session();
        send_byte(8'h11);
        send_byte(8'h22);
        reset_dut();
        vectors++;
        if ({load_enable, write_reg, write_data, busy, done, word_count, overflow} !== '0) begin
            miscompares++;
            $display("FAIL midreset_outputs: le=%b reg=%h data=%h busy=%b done=%b cnt=%0d ovf=%b, want all 0",
                     load_enable, write_reg, write_data, busy, done, word_count, overflow);
        end
        begin_session();
        send_word(32'h0102_0304);
        vectors++;
        if ({load_enable, write_reg, write_data, word_count} !== {1'b1, 32'd0, 32'h0102_0304, 6'd1}) begin
            miscompares++;
            $display("FAIL midreset_realign: le=%b reg=%0d data=%h cnt=%0d want 1,0,01020304,1",
                     load_enable, write_reg, write_data, word_count);
        end
    endtask

    task automatic test_ignored_and_restart();
        reset_dut();
        send_byte(8'hAA);
        send_byte(8'hAA);
        send_byte(8'hAA);
        send_byte(8'hAA);
        vectors++;
        if ({busy, load_enable, overflow, word_count} !== '0) begin
            miscompares++;
            $display("FAIL idle_bytes: busy=%b le=%b ovf=%b cnt=%0d want all 0", busy, load_enable, overflow, word_count);
        end
        begin_session();
        send_byte(8'h11);
        send_byte(8'h22);
        begin_session();
        send_byte(8'h33);
        send_byte(8'h44);
        vectors++;
        if ({load_enable, write_reg, write_data, word_count} !== {1'b1, 32'd0, 32'h1122_3344, 6'd1}) begin
            miscompares++;
            $display("FAIL start_in_recv: le=%b reg=%0d data=%h cnt=%0d want 1,0,11223344,1",
                     load_enable, write_reg, write_data, word_count);
        end
        send_word(32'hFFFF_FFFF);
        tick();
        send_byte(8'h55);
        vectors++;
        if ({done, overflow, word_count} !== {1'b1, 1'b1, 6'd2}) begin
            miscompares++;
            $display("FAIL done_overflow: done=%b ovf=%b cnt=%0d want 1,1,2", done, overflow, word_count);
        end
        begin_session();
        vectors++;
        if ({done, busy, overflow, word_count} !== {1'b0, 1'b1, 1'b0, 6'd0}) begin
            miscompares++;
            $display("FAIL restart_clear: done=%b busy=%b ovf=%b cnt=%0d want 0,1,0,0", done, busy, overflow, word_count);
        end
        send_word(32'h0A0B_0C0D);
        vectors++;
        if ({load_enable, write_reg, write_data, word_count} !== {1'b1, 32'd0, 32'h0A0B_0C0D, 6'd1}) begin
            miscompares++;
            $display("FAIL restart_write: le=%b reg=%0d data=%h cnt=%0d want 1,0,0a0b0c0d,1",
                     load_enable, write_reg, write_data, word_count);
        end
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_back_to_back();
        test_terminator();
        test_full_memory();
        test_mid_reset();
        test_ignored_and_restart();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
